// File: rtl/shift_reg_ctrl_if.sv
// Host-side bundle for the shift-register command sequencer: command, serial
// tx/rx streams and response, each with its own valid/ready pair.
interface shift_reg_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;

    logic             tx_valid;
    logic             tx_bit;
    logic             tx_ready;

    logic             rx_valid;
    logic             rx_bit;
    logic             rx_ready;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;

    // Host / bus side
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_count,
        output tx_ready, rx_valid, rx_bit, rsp_ready,
        input  cmd_ready, tx_valid, tx_bit, rx_ready, rsp_valid, rsp_data
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_count,
        input  tx_ready, rx_valid, rx_bit, rsp_ready,
        output cmd_ready, tx_valid, tx_bit, rx_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the 8-bit universal shift register: expands TX/RX/LOAD/READ
// commands into per-cycle select/serial/parallel drive and returns a result word.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_ctrl_if.slave  bus,
    output logic [1:0]       sr_sel,
    output logic             sr_sin,
    output logic [WIDTH-1:0] sr_pin,
    input  logic [WIDTH-1:0] sr_q
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SH_TX = 3'd2;
    localparam logic [2:0] ST_SH_RX = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] OP_TX   = 2'b00;
    localparam logic [1:0] OP_RX   = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    // The datapath has no hold code; hold is a parallel load of its own output.
    localparam logic [1:0] SEL_SHR  = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [CW-1:0] norm_count(input logic [CNT_W-1:0] c);
        logic [CW-1:0] r;
        if (c == {CNT_W{1'b0}}) begin
            r = CNT_FULL;
        end else begin
            r = CW'(c);
        end
        return r;
    endfunction

    // Next-state, latched-command and datapath/handshake drive
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        sr_sel        = SEL_LOAD;
        sr_sin        = 1'b0;
        sr_pin        = sr_q;
        bus.cmd_ready = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_bit    = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = {WIDTH{1'b0}};

        // While reset is high the datapath only ever sees hold drive.
        if (reset) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus.cmd_ready = 1'b1;
                    if (bus.cmd_valid) begin
                        op_d   = bus.cmd_op;
                        data_d = bus.cmd_data;
                        cnt_d  = norm_count(bus.cmd_count);
                        case (bus.cmd_op)
                            OP_TX:   state_d = ST_LOAD;
                            OP_LOAD: state_d = ST_LOAD;
                            OP_RX:   state_d = ST_SH_RX;
                            OP_READ: state_d = ST_DONE;
                            default: state_d = ST_IDLE;
                        endcase
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    sr_sel = SEL_LOAD;
                    sr_pin = data_q;
                    if (op_q == OP_TX) begin
                        state_d = ST_SH_TX;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_SH_TX: begin
                    bus.tx_valid = 1'b1;
                    bus.tx_bit   = sr_q[0];
                    if (bus.tx_ready) begin
                        sr_sel = SEL_SHR;
                        sr_sin = 1'b0;
                        cnt_d  = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SH_TX;
                        end
                    end else begin
                        sr_sel = SEL_LOAD;
                    end
                end
                ST_SH_RX: begin
                    bus.rx_ready = 1'b1;
                    if (bus.rx_valid) begin
                        sr_sel = SEL_SHL;
                        sr_sin = bus.rx_bit;
                        cnt_d  = cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SH_RX;
                        end
                    end else begin
                        sr_sel = SEL_LOAD;
                    end
                end
                ST_DONE: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_data  = sr_q;
                    if (bus.rsp_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State and latched-command registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_TX;
            data_q  <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
